// File: rtl/bch_pkg.sv
// Shared constants, state encoding and data placement for the (21,16) BCH codec.
package bch_pkg;

  localparam int unsigned BCH_N = 21;
  localparam int unsigned BCH_K = 16;

  // Parity positions 15, 7, 3, 1 and 0 as a mask over the codeword.
  localparam logic [BCH_N-1:0] PARITY_MASK = 21'h00808B;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } bch_state_e;

  // Scatter the payload into the codeword's data positions; parity positions left zero.
  function automatic logic [BCH_N-1:0] bch_place_data(input logic [BCH_K-1:0] d);
    logic [BCH_N-1:0] c;
    c        = '0;
    c[20:16] = d[15:11];
    c[14:8]  = d[10:4];
    c[6:4]   = d[3:1];
    c[2]     = d[0];
    return c;
  endfunction

endpackage

// File: rtl/bch_parity_gen.sv
// Combinational (21,16) codeword generator matching the decoder's bit layout.
module bch_parity_gen
  import bch_pkg::*;
(
  input  logic [BCH_K-1:0] data,
  output logic [BCH_N-1:0] codeword
);

  logic [BCH_N-1:0] placed;
  logic [BCH_N-1:0] parity;

  assign placed = bch_place_data(data);

  always_comb begin
    parity     = '0;
    parity[15] = ^placed[20:16];
    parity[7]  = ^placed[14:8];
    parity[3]  = ^{placed[20:19], placed[14:11], placed[6:4]};
    parity[1]  = ^{placed[18:17], placed[14:13], placed[10:9], placed[6:5], placed[2]};
    parity[0]  = ^{placed[20], placed[18], placed[16], placed[14], placed[12],
                   placed[10], placed[8], placed[6], placed[4], placed[2]};
  end

  assign codeword = placed | (parity & PARITY_MASK);

endmodule

// File: rtl/bch_encoder_tx.sv
// BCH (21,16) encoder with MSB-first serialiser, frame strobe and inter-frame gap.
module bch_encoder_tx
  import bch_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned GAP_BITS     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BCH_K-1:0] enc_data_in,
  input  logic             enc_valid,
  output logic             enc_ready,
  output logic [BCH_N-1:0] enc_codeword_out,
  output logic             tx_bit,
  output logic             tx_frame,
  output logic             tx_done
);

  localparam int unsigned GapCycles = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned CycW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned GapW      = (GapCycles > 1) ? $clog2(GapCycles) : 1;

  localparam logic [CycW-1:0] CycLast = CycW'(CLKS_PER_BIT - 1);
  // Unreachable when GapCycles is zero, since StGap is then skipped.
  localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);
  localparam logic [4:0]      BitLast = 5'(BCH_N - 1);

  bch_state_e       state_q;
  logic [BCH_N-1:0] shift_q;
  logic [4:0]       bit_cnt_q;
  logic [CycW-1:0]  cyc_cnt_q;
  logic [GapW-1:0]  gap_cnt_q;
  logic [BCH_N-1:0] codeword;
  logic             accept;

  bch_parity_gen u_parity_gen (
    .data     (enc_data_in),
    .codeword (codeword)
  );

  assign enc_ready = (state_q == StIdle) && !rst;
  assign accept    = enc_valid && enc_ready;

  // shift_q holds the bits still to be sent, next one at the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      shift_q          <= '0;
      bit_cnt_q        <= '0;
      cyc_cnt_q        <= '0;
      gap_cnt_q        <= '0;
      enc_codeword_out <= '0;
      tx_bit           <= 1'b0;
      tx_frame         <= 1'b0;
      tx_done          <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            enc_codeword_out <= codeword;
            shift_q          <= {codeword[BCH_N-2:0], 1'b0};
            tx_bit           <= codeword[BCH_N-1];
            tx_frame         <= 1'b1;
            bit_cnt_q        <= '0;
            cyc_cnt_q        <= '0;
            state_q          <= StShift;
          end
        end
        StShift: begin
          if (cyc_cnt_q == CycLast) begin
            cyc_cnt_q <= '0;
            if (bit_cnt_q == BitLast) begin
              tx_frame  <= 1'b0;
              tx_bit    <= 1'b0;
              tx_done   <= 1'b1;
              gap_cnt_q <= '0;
              state_q   <= (GapCycles == 0) ? StIdle : StGap;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
              tx_bit    <= shift_q[BCH_N-1];
              shift_q   <= {shift_q[BCH_N-2:0], 1'b0};
            end
          end else begin
            cyc_cnt_q <= cyc_cnt_q + CycW'(1);
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + GapW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_encoder_tx.sv
// Directed self-checking bench for bch_encoder_tx with a behavioural syndrome decoder.
module tb_bch_encoder_tx;

  localparam int unsigned Cpb = 4;
  localparam int unsigned Gap = 1;
  localparam int FrameLen = 21 * Cpb;              // 84
  localparam int DoneAt   = FrameLen + 1;          // 85
  localparam int ReadyAt  = (21 + Gap) * Cpb + 1;  // 89

  localparam logic [20:0] GrpA = 21'h1F8000;
  localparam logic [20:0] GrpB = 21'h007F80;
  localparam logic [20:0] Grp3 = 21'h187878;
  localparam logic [20:0] Grp1 = 21'h066666;
  localparam logic [20:0] Grp0 = 21'h155555;
  localparam int DataPos [16] = '{20, 19, 18, 17, 16, 14, 13, 12, 11, 10, 9, 8, 6, 5, 4, 2};

  localparam logic [15:0] VecD [4] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h8000};
  localparam logic [20:0] VecC [4] = '{21'h1FFFFE, 21'h000000, 21'h000007, 21'h108009};

  logic        clk;
  logic        rst;
  logic [15:0] enc_data_in;
  logic        enc_valid;
  logic        enc_ready;
  logic [20:0] enc_codeword_out;
  logic        tx_bit;
  logic        tx_frame;
  logic        tx_done;

  int n_cmp = 0;
  int n_bad = 0;

  bch_encoder_tx #(
    .CLKS_PER_BIT (Cpb),
    .GAP_BITS     (Gap)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enc_data_in      (enc_data_in),
    .enc_valid        (enc_valid),
    .enc_ready        (enc_ready),
    .enc_codeword_out (enc_codeword_out),
    .tx_bit           (tx_bit),
    .tx_frame         (tx_frame),
    .tx_done          (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] syndrome(input logic [20:0] r);
    return {^(r & GrpA), ^(r & GrpB), ^(r & Grp3), ^(r & Grp1), ^(r & Grp0)};
  endfunction

  function automatic logic [20:0] model_encode(input logic [15:0] d);
    logic [20:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c[DataPos[i]] = d[15-i];
    c[15] = ^(c & GrpA);
    c[7]  = ^(c & GrpB);
    c[3]  = ^(c & Grp3);
    c[1]  = ^(c & Grp1);
    c[0]  = ^(c & Grp0);
    return c;
  endfunction

  function automatic logic [15:0] model_decode(input logic [20:0] r);
    logic [4:0]  s;
    logic [15:0] d;
    s = syndrome(r);
    if (s != 5'd0) begin
      for (int p = 0; p < 21; p++) begin
        if (syndrome(21'd1 << p) == s) r[p] = ~r[p];
      end
    end
    for (int i = 0; i < 16; i++) d[15-i] = r[DataPos[i]];
    return d;
  endfunction

  // Called at a negedge; returns right after the accepting posedge.
  task automatic start_frame(input logic [15:0] d);
    int waited;
    waited      = 0;
    enc_data_in = d;
    enc_valid   = 1'b1;
    while (!enc_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_eq("accept_ready", 32'(enc_ready), 32'd1);
    @(posedge clk);
  endtask

  // mode 0: drop valid; 1: random junk on inputs while busy; 2: hold valid with next_data.
  task automatic capture(input int n_cyc, input int mode, input logic [15:0] next_data,
                         input logic [20:0] exp_cw, output logic [20:0] bits,
                         output int flen, output int ffirst, output int dcnt,
                         output int dat, output int rat, output int herr, output int cwerr);
    logic prev;
    bits = '0; flen = 0; ffirst = -1; dcnt = 0; dat = -1; rat = -1; herr = 0; cwerr = 0;
    prev = 1'b0;
    for (int n = 1; n <= n_cyc; n++) begin
      @(negedge clk);
      if (tx_frame) begin
        if (ffirst < 0) ffirst = n;
        if (flen % Cpb == 0) bits = {bits[19:0], tx_bit};
        else if (tx_bit !== prev) herr++;
        prev = tx_bit;
        flen++;
      end else if (tx_bit !== 1'b0) begin
        herr++;
      end
      if (tx_done) begin
        dcnt++;
        if (dat < 0) dat = n;
      end
      if (enc_ready && rat < 0) rat = n;
      if (enc_codeword_out !== exp_cw) cwerr++;
      if (mode == 1) begin
        enc_valid   = (n < n_cyc) ? 1'($urandom & 1) : 1'b0;
        enc_data_in = 16'($urandom);
      end else if (n == 1) begin
        enc_valid   = (mode == 2);
        enc_data_in = next_data;
      end
    end
  endtask

  task automatic frame_check(input string tag, input logic [20:0] exp_cw, input logic [20:0] bits,
                             input int flen, input int ffirst, input int dcnt, input int dat,
                             input int rat, input int herr, input int cwerr);
    check_eq({tag, "_codeword"}, 32'(cwerr), 32'd0);
    check_eq({tag, "_bits"}, 32'(bits), 32'(exp_cw));
    check_eq({tag, "_frame_start"}, 32'(ffirst), 32'd1);
    check_eq({tag, "_frame_len"}, 32'(flen), 32'(FrameLen));
    check_eq({tag, "_bit_hold"}, 32'(herr), 32'd0);
    check_eq({tag, "_done_count"}, 32'(dcnt), 32'd1);
    check_eq({tag, "_done_at"}, 32'(dat), 32'(DoneAt));
    check_eq({tag, "_ready_at"}, 32'(rat), 32'(ReadyAt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [20:0] bits;
    logic [20:0] exp_a;
    logic [20:0] exp_b;
    logic [15:0] d;
    int flen, ffirst, dcnt, dat, rat, herr, cwerr, good, seen;

    rst = 1'b1; enc_valid = 1'b0; enc_data_in = 16'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(enc_ready), 32'd0);
    check_eq("rst_frame", 32'(tx_frame), 32'd0);
    check_eq("rst_bit", 32'(tx_bit), 32'd0);
    check_eq("rst_done", 32'(tx_done), 32'd0);
    check_eq("rst_codeword", 32'(enc_codeword_out), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", 32'(enc_ready), 32'd1);
    @(negedge clk);

    // Directed parity vectors; the last one also has junk driven while busy.
    for (int v = 0; v < 4; v++) begin
      start_frame(VecD[v]);
      capture(ReadyAt, (v == 3) ? 1 : 0, VecD[v], VecC[v], bits, flen, ffirst, dcnt, dat, rat,
              herr, cwerr);
      frame_check($sformatf("vec%0d", v), VecC[v], bits, flen, ffirst, dcnt, dat, rat, herr,
                  cwerr);
    end

    // Back-to-back with valid held high.
    exp_a = model_encode(16'h1234);
    exp_b = model_encode(16'hBEEF);
    start_frame(16'h1234);
    capture(ReadyAt, 2, 16'hBEEF, exp_a, bits, flen, ffirst, dcnt, dat, rat, herr, cwerr);
    frame_check("b2b_a", exp_a, bits, flen, ffirst, dcnt, dat, rat, herr, cwerr);
    @(posedge clk);
    capture(ReadyAt, 0, 16'hBEEF, exp_b, bits, flen, ffirst, dcnt, dat, rat, herr, cwerr);
    frame_check("b2b_b", exp_b, bits, flen, ffirst, dcnt, dat, rat, herr, cwerr);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_frame) seen++;
    end
    check_eq("b2b_no_dup", 32'(seen), 32'd0);

    // Reset during bit 10 (cycles 41..44 of the frame).
    exp_a = model_encode(16'hA5C3);
    start_frame(16'hA5C3);
    capture(42, 0, 16'hA5C3, exp_a, bits, flen, ffirst, dcnt, dat, rat, herr, cwerr);
    check_eq("mid_partial_bits", 32'(bits[10:0]), 32'(exp_a[20:10]));
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_frame", 32'(tx_frame), 32'd0);
    check_eq("mid_rst_bit", 32'(tx_bit), 32'd0);
    check_eq("mid_rst_done", 32'(tx_done), 32'd0);
    check_eq("mid_rst_ready", 32'(enc_ready), 32'd0);
    check_eq("mid_rst_codeword", 32'(enc_codeword_out), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("mid_ready_after", 32'(enc_ready), 32'd1);
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_done || tx_frame) seen++;
    end
    check_eq("mid_no_activity", 32'(seen), 32'd0);
    exp_b = model_encode(16'h0F0F);
    start_frame(16'h0F0F);
    capture(ReadyAt, 0, 16'h0F0F, exp_b, bits, flen, ffirst, dcnt, dat, rat, herr, cwerr);
    frame_check("post_rst", exp_b, bits, flen, ffirst, dcnt, dat, rat, herr, cwerr);

    // Loopback through the behavioural decoder with every single-bit flip.
    for (int i = 0; i < 12; i++) begin
      d = 16'($urandom);
      start_frame(d);
      capture(ReadyAt, 0, d, model_encode(d), bits, flen, ffirst, dcnt, dat, rat, herr, cwerr);
      check_eq($sformatf("lb%0d_bits", i), 32'(bits), 32'(model_encode(d)));
      check_eq($sformatf("lb%0d_syndrome", i), 32'(syndrome(bits)), 32'd0);
      check_eq($sformatf("lb%0d_decode", i), 32'(model_decode(bits)), 32'(d));
      good = 0;
      for (int p = 0; p < 21; p++) begin
        if (model_decode(bits ^ (21'd1 << p)) == d) good++;
      end
      check_eq($sformatf("lb%0d_flips", i), 32'(good), 32'd21);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
